tape_pulse_decoder: RTL and testbench

//  Receive-side counterpart of the square-wave sound/tape generators: measures the period

---
 rtl/tape_pulse_decoder.sv | 170 +++++++++++++++++
 tb/tb_tape_pulse_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/tape_pulse_decoder.sv
// tape_pulse_decoder
//   Measures the time between rising edges of the asynchronous tape/audio comparator input
//   and classifies each period as a data bit (short = 1, long = 0), a framing error, or loss
//   of carrier. Periods are counted in whole microseconds with a clock prescaler.
//
// Parameters
//   CLK_FREQ    system clock in Hz; CLK_FREQ/1_000_000 must be an integer >= 2
//   MIN_US      periods shorter than this are glitches and are ignored
//   SPLIT_US    MIN_US <= p < SPLIT_US decodes as 1, SPLIT_US <= p <= MAX_US as 0
//   MAX_US      periods longer than this raise a framing error
//   SILENCE_US  no rising edge for this long drops the carrier (MAX_US < x < 65535)
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   enable     in   1   0 holds the decoder idle; the input synchronizer keeps running
//   tape_in    in   1   asynchronous tape/audio input
//   bit_valid  out  1   one-cycle strobe, new bit on bit_value
//   bit_value  out  1   last decoded bit, held until the next bit_valid
//   period_us  out  16  last accepted period in microseconds, held
//   err        out  1   one-cycle strobe, framing error (period > MAX_US)
//   carrier    out  1   high while a valid edge train is being tracked

module tape_pulse_decoder #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned MIN_US     = 100,
    parameter int unsigned SPLIT_US   = 600,
    parameter int unsigned MAX_US     = 1500,
    parameter int unsigned SILENCE_US = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        tape_in,
    output logic        bit_valid,
    output logic        bit_value,
    output logic [15:0] period_us,
    output logic        err,
    output logic        carrier
);

    localparam int unsigned Prescale = CLK_FREQ / 1_000_000;
    localparam int unsigned PsW      = (Prescale > 1) ? $clog2(Prescale) : 1;

    localparam logic [PsW-1:0] PsLast   = PsW'(Prescale - 1);
    localparam logic [15:0]    MinP     = 16'(MIN_US);
    localparam logic [15:0]    SplitP   = 16'(SPLIT_US);
    localparam logic [15:0]    MaxP     = 16'(MAX_US);
    // Silence fires on the tick that would take the counter to SILENCE_US.
    localparam logic [15:0]    SilLast  = 16'(SILENCE_US - 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    // Input synchronizer and registered rising-edge pulse
    logic sync1_q, sync2_q, sync3_q, rise_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= tape_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            rise_q  <= sync2_q & ~sync3_q;
        end
    end

    // Decoder state
    logic [0:0]     state_q,     state_d;
    logic [PsW-1:0] presc_q,     presc_d;
    logic [15:0]    count_q,     count_d;
    logic [15:0]    period_q,    period_d;
    logic           bit_valid_q, bit_valid_d;
    logic           bit_value_q, bit_value_d;
    logic           err_q,       err_d;
    logic           carrier_q,   carrier_d;

    logic us_tick;
    logic silence;

    assign us_tick = (presc_q == PsLast);
    assign silence = (state_q == ST_MEASURE) && us_tick && (count_q == SilLast);

    always_comb begin
        state_d     = state_q;
        presc_d     = us_tick ? '0 : presc_q + PsW'(1);
        count_d     = (us_tick && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
        period_d    = period_q;
        bit_valid_d = 1'b0;
        bit_value_d = bit_value_q;
        err_d       = 1'b0;
        carrier_d   = carrier_q;

        if (!enable) begin
            state_d   = ST_IDLE;
            presc_d   = '0;
            count_d   = '0;
            carrier_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Timebase parked at zero until the first edge arms the decoder.
                    presc_d = '0;
                    count_d = '0;
                    if (rise_q) begin
                        state_d   = ST_MEASURE;
                        carrier_d = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (silence) begin
                        // Silence wins over a coincident edge; that edge is dropped.
                        state_d   = ST_IDLE;
                        carrier_d = 1'b0;
                        presc_d   = '0;
                        count_d   = '0;
                    end else if (rise_q && (count_q >= MinP)) begin
                        // Any coincident tick is discarded: the new period starts at zero.
                        presc_d = '0;
                        count_d = '0;
                        if (count_q <= MaxP) begin
                            bit_valid_d = 1'b1;
                            bit_value_d = (count_q < SplitP);
                            period_d    = count_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    carrier_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            count_q     <= '0;
            period_q    <= '0;
            bit_valid_q <= 1'b0;
            bit_value_q <= 1'b0;
            err_q       <= 1'b0;
            carrier_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            count_q     <= count_d;
            period_q    <= period_d;
            bit_valid_q <= bit_valid_d;
            bit_value_q <= bit_value_d;
            err_q       <= err_d;
            carrier_q   <= carrier_d;
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_value = bit_value_q;
    assign period_us = period_q;
    assign err       = err_q;
    assign carrier   = carrier_q;

endmodule

// File: tb/tb_tape_pulse_decoder.sv
// tb_tape_pulse_decoder
//   Directed bench for tape_pulse_decoder at 4 MHz (4 clocks per microsecond).
//   Every rising edge is driven 1 ns after a clock edge, so edge spacing is an exact clock
//   count. A spacing of 4*T+2 clocks measures as T whole microseconds. The silence timeout
//   is shortened to 4000 us to keep the run short; the timeout mechanism is identical.

`timescale 1ns/1ps

module tb_tape_pulse_decoder;

    localparam int KArm = 0;
    localparam int KBit = 1;
    localparam int KErr = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        tape_in;
    logic        bit_valid;
    logic        bit_value;
    logic [15:0] period_us;
    logic        err;
    logic        carrier;

    int checks   = 0;
    int failures = 0;

    always #125 clk = ~clk;

    tape_pulse_decoder #(
        .CLK_FREQ  (4_000_000),
        .MIN_US    (100),
        .SPLIT_US  (600),
        .MAX_US    (1500),
        .SILENCE_US(4000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .tape_in  (tape_in),
        .bit_valid(bit_valid),
        .bit_value(bit_value),
        .period_us(period_us),
        .err      (err),
        .carrier  (carrier)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge followed by len clocks (high for 80 clocks, then low).
    // The strobe for this edge is expected 4 clocks after it is driven.
    task automatic seg(input string tag, input int len, input int kind, input int exp_p,
                       input logic exp_b, input int fall_at);
        int stray;
        stray   = 0;
        tape_in = 1'b1;
        for (int i = 1; i <= len; i++) begin
            tick();
            if (i == 80) tape_in = 1'b0;
            if (i == 4) begin
                check($sformatf("%s.bit_valid", tag), 32'(bit_valid), 32'(kind == KBit));
                check($sformatf("%s.err", tag), 32'(err), 32'(kind == KErr));
                check($sformatf("%s.carrier", tag), 32'(carrier), 32'd1);
                check($sformatf("%s.period_us", tag), 32'(period_us), 32'(exp_p));
                check($sformatf("%s.bit_value", tag), 32'(bit_value), 32'(exp_b));
            end else if (bit_valid || err) begin
                stray++;
            end
            if (fall_at > 0 && i == fall_at - 1)
                check($sformatf("%s.carrier_before_silence", tag), 32'(carrier), 32'd1);
            if (fall_at > 0 && i == fall_at)
                check($sformatf("%s.carrier_after_silence", tag), 32'(carrier), 32'd0);
        end
        check($sformatf("%s.stray_strobes", tag), 32'(stray), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        tape_in = 1'b0;

        // 1: reset with the input toggling
        for (int i = 0; i < 3; i++) begin
            tape_in = ~tape_in;
            tick();
            check($sformatf("reset.c%0d", i),
                  {11'd0, bit_valid, bit_value, err, carrier, period_us}, 32'd0);
        end
        tape_in = 1'b0;
        reset   = 1'b0;
        repeat (6) tick();
        check("post_reset", {11'd0, bit_valid, bit_value, err, carrier, period_us}, 32'd0);

        // 2: 300 us square wave, five edges
        seg("sq.e1", 1202, KArm, 0, 1'b0, 0);
        seg("sq.e2", 1202, KBit, 300, 1'b1, 0);
        seg("sq.e3", 1202, KBit, 300, 1'b1, 0);
        seg("sq.e4", 1202, KBit, 300, 1'b1, 0);
        seg("sq.e5", 4 * 599 + 2, KBit, 300, 1'b1, 0);

        // 3: boundaries 599, 600, 1500, 1501 us
        seg("bnd.599", 4 * 600 + 2, KBit, 599, 1'b1, 0);
        seg("bnd.600", 4 * 1500 + 2, KBit, 600, 1'b0, 0);
        seg("bnd.1500", 4 * 1501 + 2, KBit, 1500, 1'b0, 0);
        // The framing-error edge becomes the reference for the glitch test.
        seg("bnd.1501", 4 * 50 + 2, KErr, 1500, 1'b0, 0);

        // 4: glitch 50 us after the reference, real edge 400 us after it
        seg("glitch", 1400, KArm, 1500, 1'b0, 0);

        // 5: silence after the 400 us bit, then re-arm and an 800 us bit
        seg("gl.real", 16010, KBit, 400, 1'b1, 16004);
        seg("sil.rearm", 4 * 800 + 2, KArm, 400, 1'b1, 0);
        seg("sil.800", 1000, KBit, 800, 1'b0, 0);

        // 6: enable dropped mid-measurement
        enable = 1'b0;
        repeat (10) tick();
        check("en.carrier", 32'(carrier), 32'd0);
        check("en.period_us", 32'(period_us), 32'd800);
        check("en.bit_value", 32'(bit_value), 32'd0);
        check("en.strobes", {30'd0, bit_valid, err}, 32'd0);
        enable = 1'b1;
        repeat (10) tick();
        seg("en.rearm", 1202, KArm, 800, 1'b0, 0);
        seg("en.300", 100, KBit, 300, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
